// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters share a single 8-bit ripple adder.
// A round-robin arbiter picks a requester. An IDLE/EXEC/DONE sequencer then
// latches that requester's operands and gives the adder LAT cycles to settle.
// After that it captures the sum and pulses done to the owner.

// carry_adder: 8-bit ripple-carry adder, {c_out, s} = a + b + c_in.
module carry_adder (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       c_in,
   output logic [7:0] s,
   output logic       c_out
);
   logic carry;

   // Ripple the carry from bit 0 upward, one full-adder cell per bit.
   always_comb begin
      // NOTE: blocking assignments here, so each bit sees the carry produced
      // by the bit below it within the same evaluation.
      carry = c_in;
      s     = '0;
      for (int i = 0; i < 8; i++) begin
         s[i]  = a[i] ^ b[i] ^ carry;
         carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      c_out = carry;
   end
endmodule

// adder_arbiter: round-robin front end plus settle sequencer around carry_adder.
module adder_arbiter #(
   parameter int LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic [7:0] a0,
   input  logic [7:0] b0,
   input  logic       c_in0,
   input  logic       req1,
   input  logic [7:0] a1,
   input  logic [7:0] b1,
   input  logic       c_in1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic [7:0] s,
   output logic       c_out,
   output logic       busy
);
   // A LAT outside 1..4 falls back to a single settle cycle.
   localparam int         LAT_EFF  = ((LAT >= 1) && (LAT <= 4)) ? LAT : 1;
   localparam logic [2:0] LAT_LOAD = 3'(LAT_EFF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_q;
   logic [2:0] cnt_q;
   logic [7:0] op_a_q;
   logic [7:0] op_b_q;
   logic       op_c_q;
   logic       last_q;    // requester served most recently (0 or 1)
   logic       owner_q;   // requester that owns the operation in flight
   logic       gnt0_q;
   logic       gnt1_q;
   logic       done0_q;
   logic       done1_q;
   logic [7:0] s_q;
   logic       c_out_q;
   logic       busy_q;

   logic       any_req;
   logic       owner_d;
   logic [7:0] add_s;
   logic       add_c;

   assign any_req = req0 | req1;

   // Round-robin pick: a lone request wins outright. On a tie, the
   // requester that was not served last wins.
   always_comb begin
      // NOTE: default first, so every path assigns owner_d and no latch
      // can be inferred.
      owner_d = 1'b0;
      if (req0 && req1) begin
         owner_d = ~last_q;
      end else if (req1) begin
         owner_d = 1'b1;
      end
   end

   // The shared adder only ever sees the latched operands. Input changes
   // after the grant cannot reach it.
   carry_adder u_adder (
      .a     (op_a_q),
      .b     (op_b_q),
      .c_in  (op_c_q),
      .s     (add_s),
      .c_out (add_c)
   );

   // Sequencer: grant and latch in IDLE, count down the settle time in EXEC,
   // and signal completion in DONE. All outputs are registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the operand registers are cleared along with the control
         // state, so the adder inputs are defined right after reset.
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         op_a_q  <= 8'd0;
         op_b_q  <= 8'd0;
         op_c_q  <= 1'b0;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         s_q     <= 8'd0;
         c_out_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every register samples the
         // values from before the edge.
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  owner_q <= owner_d;
                  last_q  <= owner_d;
                  op_a_q  <= owner_d ? a1    : a0;
                  op_b_q  <= owner_d ? b1    : b0;
                  op_c_q  <= owner_d ? c_in1 : c_in0;
                  cnt_q   <= LAT_LOAD;
                  gnt0_q  <= ~owner_d;
                  gnt1_q  <= owner_d;
                  busy_q  <= 1'b1;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               cnt_q <= cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  s_q     <= add_s;
                  c_out_q <= add_c;
                  done0_q <= ~owner_q;
                  done1_q <= owner_q;
                  state_q <= DONE;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt0  = gnt0_q;
   assign gnt1  = gnt1_q;
   assign done0 = done0_q;
   assign done1 = done1_q;
   assign s     = s_q;
   assign c_out = c_out_q;
   assign busy  = busy_q;
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter LAT, default 1, adder settle cycles per operation; legal range 1-4.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0  input  1  requester 0 request, level.
REQ-005 a0  input  8  requester 0 operand A.
REQ-006 b0  input  8  requester 0 operand B.
REQ-007 c_in0  input  1  requester 0 carry-in.
REQ-008 req1, a1, b1, c_in1  input  1/8/8/1  requester 1 request, operands, carry-in; same meaning as the requester 0 ports.
REQ-009 gnt0, gnt1  output  1 each  one-cycle grant pulse to the accepted requester.
REQ-010 done0, done1  output  1 each  one-cycle result-valid pulse to the owning requester.
REQ-011 s  output  8  registered sum of last completed operation.
REQ-012 c_out  output  1  registered carry-out of last completed operation.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 Block SHALL contain exactly one instance of the team's 8-bit ripple adder carry_adder (ports a, b, c_in, s, c_out), shared by both requesters.
REQ-015 FSM states SHALL be IDLE, EXEC, DONE.
REQ-016 IDLE: on an edge with req0 or req1 high, SHALL select one requester, latch its a, b, c_in into internal operand registers, load the settle counter with LAT, and enter EXEC.
REQ-017 Arbitration: single request -> that requester; both requesting -> the requester not served last (round-robin); last-served pointer resets to 1, so req0 wins the first tie.
REQ-018 Last-served pointer SHALL update only on a grant.
REQ-019 gnt of the selected requester SHALL be high for exactly the first EXEC cycle; the two gnt outputs are never high together.
REQ-020 Operands SHALL be sampled only at grant; operand input changes after grant have no effect on the operation in progress.
REQ-021 EXEC: the adder SHALL be driven only from the operand registers; the counter decrements each cycle; on the edge where counter==1, SHALL capture adder s and c_out into the s/c_out registers and enter DONE.
REQ-022 DONE: done of the owning requester SHALL be high for this one cycle; next state IDLE unconditionally.
REQ-023 Latency: request sampled at edge k -> gnt high in cycle k+1, done high in cycle k+LAT+1; throughput one operation per LAT+2 cycles.
REQ-024 Arithmetic: {c_out,s} SHALL equal (a + b + c_in) mod 512, unsigned.
REQ-025 s/c_out SHALL hold their value from DONE until the next DONE capture.
REQ-026 A requester holding req high through its own DONE cycle SHALL be treated as a new request in the following IDLE cycle, subject to REQ-017.
REQ-027 Requests arriving while busy SHALL be ignored until IDLE; there is no queuing beyond the level of req.
REQ-028 An out-of-range LAT (0 or greater than 4) SHALL be treated as 1.

Reset
REQ-029 With rst high at an edge: state IDLE, counter 0, operand registers 0, pointer 1, s=0, c_out=0, gnt0/gnt1/done0/done1/busy=0.
REQ-030 Reset SHALL override any state, including mid-EXEC; an aborted operation SHALL NOT produce done or update s/c_out.

Verification (LAT=1 unless noted)
REQ-031 req0=1, a0=3, b0=2, c_in0=0 -> gnt0 next cycle, done0 one cycle later, s=5, c_out=0.
REQ-032 req0 and req1 asserted together after reset, a0=12/b0=3/c_in0=0, a1=14/b1=1/c_in1=1 -> requester 0 served first (s=15); requester 1 served next (s=16, c_out=0, done1).
REQ-033 Both req held high for 4 operations -> grants alternate 0,1,0,1; gnt0 and gnt1 never high in the same cycle.
REQ-034 a0=255, b0=1, c_in0=1 -> s=1, c_out=1; a0=255, b0=255, c_in0=1 -> s=255, c_out=1.
REQ-035 LAT=3, single request at edge k -> busy for 4 cycles, done in cycle k+4; operand inputs changed after gnt do not alter the result.
REQ-036 rst pulsed during EXEC -> no done pulse, s/c_out=0, busy=0 on the next cycle; a request held through reset is granted on the first IDLE edge after reset.
